pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of each performance counter.
REQ-002 Parameter TIMEOUT, default 1024: consecutive memory-busy cycles before timeout flag sets.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 im_stall_i  input  1  instruction-memory access not complete this cycle.
REQ-006 dm_stall_i  input  1  data-memory access not complete this cycle.
REQ-007 ld_stall_i  input  1  load-use hazard detected (hazard unit stall).
REQ-008 flush_i  input  1  taken branch/jump/CSR redirect (hazard unit flush).
REQ-009 int_req_i  input  1  level interrupt request from CSR unit.
REQ-010 pc_en_o, if_id_en_o, id_exe_en_o, exe_mem_en_o, mem_wb_en_o  output  1 each  pipeline register write enables.
REQ-011 if_id_flush_o, id_exe_flush_o  output  1 each  insert bubble into IF/ID, ID/EXE.
REQ-012 int_ack_o  output  1  one-cycle interrupt acceptance pulse.
REQ-013 timeout_o  output  1  sticky memory-timeout flag.
REQ-014 stall_cnt_o, bubble_cnt_o, flush_cnt_o  output  CNT_W each  performance counters.

Function
REQ-015 mem_busy = im_stall_i | dm_stall_i; all control outputs combinational from inputs and registered state, same cycle.
REQ-016 States: RUN, WAIT, INT_HOLD; registered flush_pend bit; registered busy-run counter (width clog2(TIMEOUT+1)).
REQ-017 Priority per cycle: mem_busy > (flush_i | flush_pend | interrupt take) > ld_stall_i > normal.
REQ-018 mem_busy=1: all five enables 0, both flush outputs 0, int_ack_o 0; next state WAIT (INT_HOLD stays INT_HOLD); flush_pend <= flush_pend | flush_i.
REQ-019 Flush case (mem_busy=0, flush_i|flush_pend): all enables 1, if_id_flush_o=1, id_exe_flush_o=1, flush_pend <= 0, flush_cnt_o += 1; ld_stall_i ignored.
REQ-020 Interrupt take: mem_busy=0, state RUN or WAIT, int_req_i=1: int_ack_o=1 for exactly this cycle, flush outputs as REQ-019 (counted once in flush_cnt_o even if flush_i also 1), next state INT_HOLD.
REQ-021 INT_HOLD: no further int_ack_o; returns to RUN in the cycle after int_req_i observed 0 with mem_busy=0; flush_i/ld_stall_i handled normally while in INT_HOLD.
REQ-022 Load-use case (mem_busy=0, no flush, no interrupt take, ld_stall_i=1): pc_en_o=0, if_id_en_o=0, id_exe_en_o=1, id_exe_flush_o=1, if_id_flush_o=0, exe_mem_en_o=1, mem_wb_en_o=1; bubble_cnt_o += 1.
REQ-023 Normal case: all enables 1, flush outputs 0, int_ack_o 0.
REQ-024 WAIT exits to RUN on first cycle with mem_busy=0 (or INT_HOLD per REQ-020); pending flush applied in that exit cycle.
REQ-025 stall_cnt_o += 1 every cycle mem_busy=1; all counters wrap modulo 2^CNT_W, no saturation.
REQ-026 Busy-run counter increments while mem_busy=1, clears when mem_busy=0, saturates at TIMEOUT; timeout_o sets when it reaches TIMEOUT and holds until reset.
REQ-027 Flush outputs never assert in a cycle where any enable they pair with is 0.

Reset
REQ-028 rst=1 asynchronously forces state RUN, flush_pend 0, busy-run counter 0, timeout_o 0, all three counters 0.
REQ-029 During reset outputs follow REQ-015..023 using reset state (int_ack_o 0 only if int_req_i=0); reset mid-WAIT discards any pending flush.

Verification
REQ-030 ld_stall_i=1 one cycle, others 0 -> pc_en_o=0, if_id_en_o=0, id_exe_flush_o=1 that cycle; bubble_cnt_o=1 next cycle.
REQ-031 dm_stall_i=1 for 5 cycles, flush_i pulsed in 2nd -> enables 0 for 5 cycles, both flush outputs 1 in 6th cycle only; stall_cnt_o=5, flush_cnt_o=1.
REQ-032 flush_i=1 and ld_stall_i=1 same cycle -> pc_en_o=1, both flush outputs 1, bubble_cnt_o unchanged.
REQ-033 int_req_i high 4 cycles, no stalls -> int_ack_o=1 in first cycle only, flush outputs that cycle, state RUN after int_req_i drops.
REQ-034 TIMEOUT=8, im_stall_i held 8 cycles -> timeout_o=1 from cycle 9, stays 1 after im_stall_i drops; rst=1 clears it.
REQ-035 CNT_W=4, 17 load-use bubbles -> bubble_cnt_o=1 (wrap).

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl: pipeline stall/flush/interrupt sequencer with perf counters     |
// |            and a sticky memory-timeout flag.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             im_stall_i,
  input  logic             dm_stall_i,
  input  logic             ld_stall_i,
  input  logic             flush_i,
  input  logic             int_req_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_exe_en_o,
  output logic             exe_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_exe_flush_o,
  output logic             int_ack_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int c_run_w = $clog2(TIMEOUT + 1);
  localparam logic [c_run_w-1:0] c_timeout = c_run_w'(TIMEOUT);
  localparam logic [c_run_w-1:0] c_run_one = c_run_w'(1);
  localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT     = 2'd1,
    ST_INT_HOLD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_flush_pend;
  logic               w_flush_pend_nxt;
  logic [c_run_w-1:0] r_busy_run;
  logic [c_run_w-1:0] w_busy_run_nxt;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_bubble_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic w_mem_busy;
  logic w_int_take;
  logic w_do_flush;
  logic w_do_bubble;

  // Case selection: memory busy dominates, then any redirect, then load-use.
  assign w_mem_busy  = im_stall_i | dm_stall_i;
  assign w_int_take  = ~w_mem_busy & int_req_i & (r_state != ST_INT_HOLD);
  assign w_do_flush  = ~w_mem_busy & (flush_i | r_flush_pend | w_int_take);
  assign w_do_bubble = ~w_mem_busy & ~w_do_flush & ld_stall_i;

  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_exe_en_o    = 1'b1;
    exe_mem_en_o   = 1'b1;
    mem_wb_en_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_exe_flush_o = 1'b0;
    int_ack_o      = 1'b0;
    if (w_mem_busy) begin
      pc_en_o      = 1'b0;
      if_id_en_o   = 1'b0;
      id_exe_en_o  = 1'b0;
      exe_mem_en_o = 1'b0;
      mem_wb_en_o  = 1'b0;
    end else if (w_do_flush) begin
      if_id_flush_o  = 1'b1;
      id_exe_flush_o = 1'b1;
      int_ack_o      = w_int_take;
    end else if (w_do_bubble) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_exe_flush_o = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_mem_busy) begin
      if (r_state != ST_INT_HOLD) begin
        w_state_nxt = ST_WAIT;
      end
    end else if (w_int_take) begin
      w_state_nxt = ST_INT_HOLD;
    end else if (r_state == ST_INT_HOLD) begin
      if (!int_req_i) begin
        w_state_nxt = ST_RUN;
      end
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  // A redirect seen while memory is busy is remembered and applied on exit.
  assign w_flush_pend_nxt = w_mem_busy & (r_flush_pend | flush_i);

  always_comb begin
    w_busy_run_nxt = '0;
    if (w_mem_busy) begin
      w_busy_run_nxt = (r_busy_run == c_timeout) ? r_busy_run : r_busy_run + c_run_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_pend <= 1'b0;
      r_busy_run   <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_busy_run   <= w_busy_run_nxt;
      if (w_busy_run_nxt == c_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Performance counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_mem_busy) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
      if (w_do_bubble) begin
        r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
      end
      if (w_do_flush) begin
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
    end
  end

  assign timeout_o    = r_timeout;
  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;

endmodule
`default_nettype wire
